// File: rtl/rackbus_cmd_pkg.sv
// Shared field layout, mark FSM states and parity helper
// for the SURF command word.
package rackbus_cmd_pkg;

  localparam int RACKBUS_RUNCMD_BITS = 2;
  localparam int RACKBUS_TRIG_BITS   = 15;
  localparam int FW_BITS             = 8;
  localparam int MARK_BITS           = 2;

  localparam int FW_DAT_LSB   = 0;
  localparam int FW_VLD_BIT   = 8;
  localparam int MARK_LSB     = 9;
  localparam int TRIG_LSB     = 12;
  localparam int TRIG_VLD_BIT = 27;
  localparam int RUNCMD_LSB   = 28;
  localparam int PAR_BIT      = 31;

  typedef enum logic [1:0] {
    M_IDLE,
    M_SEND,
    M_WAIT
  } mark_state_e;

  // Even parity: the full 32-bit word has an even number of ones.
  function automatic logic cmd_parity(
    input logic [30:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// Single-entry AXI4-Stream hold register; tready is
// simply "hold empty", and clear_i drops the held beat.
module axis_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] tdata_i,
  input  logic         tvalid_i,
  output logic         tready_o,
  input  logic         clear_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         valid_q;
  logic         valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end
    if (tvalid_i && !valid_q) begin
      valid_d = 1'b1;
      data_d  = tdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign tready_o = !valid_q;
  assign data_o   = data_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/surfturf_cmd_framer.sv
// Packs runcmd, trigger, firmware byte and firmware mark
// into one parity-protected command word per frame strobe.
module surfturf_cmd_framer
  import rackbus_cmd_pkg::*;
#(
  parameter int FW_DIV = 1
) (
  input  logic                           sysclk_i,
  input  logic                           sysclk_rst_i,
  input  logic                           cmd_frame_i,
  input  logic [RACKBUS_RUNCMD_BITS-1:0] runcmd_tdata,
  input  logic                           runcmd_tvalid,
  output logic                           runcmd_tready,
  input  logic [RACKBUS_TRIG_BITS-1:0]   trig_tdata,
  input  logic                           trig_tvalid,
  output logic                           trig_tready,
  input  logic [FW_BITS-1:0]             fw_tdata,
  input  logic                           fw_tvalid,
  output logic                           fw_tready,
  input  logic [MARK_BITS-1:0]           fw_mark_i,
  output logic                           fw_marked_o,
  output logic [31:0]                    cmd_dat_o,
  output logic                           cmd_valid_o,
  output logic [15:0]                    frame_count_o
);

  localparam logic [3:0] SLOT_LAST = 4'(FW_DIV - 1);

  logic [RACKBUS_RUNCMD_BITS-1:0] rc_dat;
  logic                           rc_vld;
  logic                           rc_clr;
  logic [RACKBUS_TRIG_BITS-1:0]   tr_dat;
  logic                           tr_vld;
  logic                           tr_clr;
  logic [FW_BITS-1:0]             fw_dat;
  logic                           fw_vld;
  logic                           fw_clr;

  logic [3:0]  slot_q;
  logic [3:0]  slot_d;
  logic        is_slot;
  logic        send_mark;
  logic [31:0] word;

  mark_state_e state_q;
  mark_state_e state_d;

  logic [31:0] cmd_dat_q;
  logic [31:0] cmd_dat_d;
  logic        cmd_valid_q;
  logic        cmd_valid_d;
  logic        fw_marked_q;
  logic        fw_marked_d;
  logic [15:0] frame_count_q;
  logic [15:0] frame_count_d;

  assign is_slot = (slot_q == 4'd0);
  assign rc_clr  = cmd_frame_i && rc_vld;
  assign tr_clr  = cmd_frame_i && tr_vld;
  // Firmware bytes only leave on slot frames.
  assign fw_clr  = cmd_frame_i && is_slot && fw_vld;

  axis_hold_reg #(.W(RACKBUS_RUNCMD_BITS)) u_rc_hold (
    .clk_i    (sysclk_i),
    .rst_i    (sysclk_rst_i),
    .tdata_i  (runcmd_tdata),
    .tvalid_i (runcmd_tvalid),
    .tready_o (runcmd_tready),
    .clear_i  (rc_clr),
    .data_o   (rc_dat),
    .valid_o  (rc_vld)
  );

  axis_hold_reg #(.W(RACKBUS_TRIG_BITS)) u_tr_hold (
    .clk_i    (sysclk_i),
    .rst_i    (sysclk_rst_i),
    .tdata_i  (trig_tdata),
    .tvalid_i (trig_tvalid),
    .tready_o (trig_tready),
    .clear_i  (tr_clr),
    .data_o   (tr_dat),
    .valid_o  (tr_vld)
  );

  axis_hold_reg #(.W(FW_BITS)) u_fw_hold (
    .clk_i    (sysclk_i),
    .rst_i    (sysclk_rst_i),
    .tdata_i  (fw_tdata),
    .tvalid_i (fw_tvalid),
    .tready_o (fw_tready),
    .clear_i  (fw_clr),
    .data_o   (fw_dat),
    .valid_o  (fw_vld)
  );

  always_comb begin
    slot_d = slot_q;
    if (cmd_frame_i) begin
      if (slot_q >= SLOT_LAST) begin
        slot_d = 4'd0;
      end else begin
        slot_d = slot_q + 4'd1;
      end
    end
  end

  // A mark may only go out once every queued byte has left,
  // including one arriving on the frame cycle itself.
  always_comb begin
    state_d   = state_q;
    send_mark = 1'b0;
    unique case (state_q)
      M_IDLE: begin
        if (|fw_mark_i) begin
          state_d = M_SEND;
        end
      end
      M_SEND: begin
        if (!(|fw_mark_i)) begin
          state_d = M_IDLE;
        end else if (cmd_frame_i && is_slot &&
                     !fw_vld && !fw_tvalid) begin
          send_mark = 1'b1;
          state_d   = M_WAIT;
        end
      end
      M_WAIT: begin
        if (!(|fw_mark_i)) begin
          state_d = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_comb begin
    word = '0;
    if (is_slot && fw_vld) begin
      word[FW_DAT_LSB +: FW_BITS] = fw_dat;
      word[FW_VLD_BIT]            = 1'b1;
    end
    if (send_mark) begin
      word[MARK_LSB +: MARK_BITS] = fw_mark_i;
    end
    if (tr_vld) begin
      word[TRIG_LSB +: RACKBUS_TRIG_BITS] = tr_dat;
      word[TRIG_VLD_BIT]                  = 1'b1;
    end
    if (rc_vld) begin
      word[RUNCMD_LSB +: RACKBUS_RUNCMD_BITS] = rc_dat;
    end
    word[PAR_BIT] = cmd_parity(word[30:0]);
  end

  always_comb begin
    cmd_dat_d     = cmd_dat_q;
    cmd_valid_d   = cmd_frame_i;
    fw_marked_d   = send_mark;
    frame_count_d = frame_count_q;
    if (cmd_frame_i) begin
      cmd_dat_d     = word;
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      state_q       <= M_IDLE;
      slot_q        <= 4'd0;
      cmd_dat_q     <= '0;
      cmd_valid_q   <= 1'b0;
      fw_marked_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cmd_dat_q     <= cmd_dat_d;
      cmd_valid_q   <= cmd_valid_d;
      fw_marked_q   <= fw_marked_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign cmd_dat_o     = cmd_dat_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign fw_marked_o   = fw_marked_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_surfturf_cmd_framer.sv
// Bench for surfturf_cmd_framer: FW_DIV=1 and FW_DIV=3
// instances, vector table plus hand-written sequences.
module tb_surfturf_cmd_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        frame;
  logic [1:0]  rc_d;
  logic        rc_v;
  logic        rc_rdy;
  logic [14:0] tr_d;
  logic        tr_v;
  logic        tr_rdy;
  logic [7:0]  fw_d;
  logic        fw_v;
  logic        fw_rdy;
  logic [1:0]  mark;
  logic        marked;
  logic [31:0] dat;
  logic        valid;
  logic [15:0] cnt;

  logic        frame3;
  logic [1:0]  rc3_d;
  logic        rc3_v;
  logic        rc3_rdy;
  logic [14:0] tr3_d;
  logic        tr3_v;
  logic        tr3_rdy;
  logic [7:0]  fw3_d;
  logic        fw3_v;
  logic        fw3_rdy;
  logic [1:0]  mark3;
  logic        marked3;
  logic [31:0] dat3;
  logic        valid3;
  logic [15:0] cnt3;

  surfturf_cmd_framer #(.FW_DIV(1)) u_dut1 (
    .sysclk_i      (clk),
    .sysclk_rst_i  (rst),
    .cmd_frame_i   (frame),
    .runcmd_tdata  (rc_d),
    .runcmd_tvalid (rc_v),
    .runcmd_tready (rc_rdy),
    .trig_tdata    (tr_d),
    .trig_tvalid   (tr_v),
    .trig_tready   (tr_rdy),
    .fw_tdata      (fw_d),
    .fw_tvalid     (fw_v),
    .fw_tready     (fw_rdy),
    .fw_mark_i     (mark),
    .fw_marked_o   (marked),
    .cmd_dat_o     (dat),
    .cmd_valid_o   (valid),
    .frame_count_o (cnt)
  );

  surfturf_cmd_framer #(.FW_DIV(3)) u_dut3 (
    .sysclk_i      (clk),
    .sysclk_rst_i  (rst),
    .cmd_frame_i   (frame3),
    .runcmd_tdata  (rc3_d),
    .runcmd_tvalid (rc3_v),
    .runcmd_tready (rc3_rdy),
    .trig_tdata    (tr3_d),
    .trig_tvalid   (tr3_v),
    .trig_tready   (tr3_rdy),
    .fw_tdata      (fw3_d),
    .fw_tvalid     (fw3_v),
    .fw_tready     (fw3_rdy),
    .fw_mark_i     (mark3),
    .fw_marked_o   (marked3),
    .cmd_dat_o     (dat3),
    .cmd_valid_o   (valid3),
    .frame_count_o (cnt3)
  );

  typedef struct {
    logic        rv;
    logic [1:0]  r;
    logic        tv;
    logic [14:0] t;
    logic        fv;
    logic [7:0]  f;
    logic [31:0] exp_w;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic        mk;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  vec_t vecs[6];
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int exp_cnt3 = 0;

  function automatic logic [31:0] mk_word(
    input logic fv, input logic [7:0] f,
    input logic [1:0] m,
    input logic tv, input logic [14:0] t,
    input logic [1:0] r);
    logic [31:0] w;
    w = 32'h0;
    if (fv) w[8:0] = {1'b1, f};
    w[10:9] = m;
    if (tv) w[27:12] = {1'b1, t};
    w[29:28] = r;
    w[31] = ^w[30:0];
    return w;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic drive(input logic rv, input logic [1:0] r,
                       input logic tv, input logic [14:0] t,
                       input logic fv, input logic [7:0] f);
    rc_v = rv; rc_d = r;
    tr_v = tv; tr_d = t;
    fw_v = fv; fw_d = f;
    @(posedge clk);
    @(negedge clk);
    rc_v = 1'b0; tr_v = 1'b0; fw_v = 1'b0;
  endtask

  task automatic do_frame(input logic [31:0] w,
                          input logic mk);
    exp_t e;
    q1.push_back('{w: w, mk: mk});
    frame = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame = 1'b0;
    rc_v = 1'b0; tr_v = 1'b0; fw_v = 1'b0;
    exp_cnt++;
    chk("valid_pulse", 32'(valid), 32'd1);
    if (q1.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = q1.pop_front();
      chk("cmd_dat", dat, e.w);
      chk("marked", 32'(marked), 32'(e.mk));
    end
    chk("frame_count", 32'(cnt), 32'(exp_cnt));
    @(negedge clk);
    chk("valid_low", 32'(valid), 32'd0);
    chk("marked_low", 32'(marked), 32'd0);
    chk("dat_hold", dat, w);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_frame3(input logic [31:0] w);
    exp_t e;
    q3.push_back('{w: w, mk: 1'b0});
    frame3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame3 = 1'b0;
    exp_cnt3++;
    chk("valid3_pulse", 32'(valid3), 32'd1);
    if (q3.size() == 0) begin
      chk("queue3_empty", 32'd0, 32'd1);
    end else begin
      e = q3.pop_front();
      chk("cmd_dat3", dat3, e.w);
    end
    chk("frame_count3", 32'(cnt3), 32'(exp_cnt3));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    frame = 1'b0; rc_d = '0; rc_v = 1'b0;
    tr_d = '0; tr_v = 1'b0; fw_d = '0; fw_v = 1'b0;
    mark = '0;
    frame3 = 1'b0; rc3_d = '0; rc3_v = 1'b0;
    tr3_d = '0; tr3_v = 1'b0; fw3_d = '0; fw3_v = 1'b0;
    mark3 = '0;

    vecs[0] = '{1, 2'b10, 0, 15'h0,    0, 8'h00, 32'hA000_0000};
    vecs[1] = '{0, 2'b00, 1, 15'h1234, 1, 8'hA5, 32'h8923_41A5};
    vecs[2] = '{0, 2'b00, 0, 15'h0,    0, 8'h00, 32'h0000_0000};
    vecs[3] = '{1, 2'b11, 1, 15'h7FFF, 1, 8'hFF, 32'hBFFF_F1FF};
    vecs[4] = '{1, 2'b01, 1, 15'h0001, 1, 8'h00, 32'h1800_1100};
    vecs[5] = '{1, 2'b00, 0, 15'h0,    1, 8'h80, 32'h0000_0180};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rc_rdy", 32'(rc_rdy), 32'd1);
    chk("rst_tr_rdy", 32'(tr_rdy), 32'd1);
    chk("rst_fw_rdy", 32'(fw_rdy), 32'd1);
    chk("rst_dat", dat, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_marked", 32'(marked), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_fw3_rdy", 32'(fw3_rdy), 32'd1);
    chk("rst_cnt3", 32'(cnt3), 32'd0);

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rv, vecs[i].r, vecs[i].tv, vecs[i].t,
            vecs[i].fv, vecs[i].f);
      chk("held_rc_rdy", 32'(rc_rdy), 32'(!vecs[i].rv));
      chk("held_tr_rdy", 32'(tr_rdy), 32'(!vecs[i].tv));
      chk("held_fw_rdy", 32'(fw_rdy), 32'(!vecs[i].fv));
      @(negedge clk);
      do_frame(vecs[i].exp_w, 1'b0);
      chk("post_rc_rdy", 32'(rc_rdy), 32'd1);
      chk("post_tr_rdy", 32'(tr_rdy), 32'd1);
      chk("post_fw_rdy", 32'(fw_rdy), 32'd1);
    end

    // trig beat on the frame cycle lands in the next word
    tr_v = 1'b1; tr_d = 15'h0ABC;
    do_frame(32'h0, 1'b0);
    do_frame(mk_word(0, 8'h0, 2'b00, 1, 15'h0ABC, 2'b00), 1'b0);

    // full hold stalls a beat offered on the frame cycle
    drive(1, 2'b01, 0, 15'h0, 0, 8'h0);
    rc_v = 1'b1; rc_d = 2'b11;
    do_frame(mk_word(0, 8'h0, 2'b00, 0, 15'h0, 2'b01), 1'b0);
    chk("stall_rc_rdy", 32'(rc_rdy), 32'd1);
    do_frame(32'h0, 1'b0);

    // mark ordered behind queued firmware bytes
    drive(0, 2'b00, 0, 15'h0, 1, 8'h11);
    mark = 2'b01;
    @(negedge clk);
    @(negedge clk);
    do_frame(mk_word(1, 8'h11, 2'b00, 0, 15'h0, 2'b00), 1'b0);
    drive(0, 2'b00, 0, 15'h0, 1, 8'h22);
    do_frame(mk_word(1, 8'h22, 2'b00, 0, 15'h0, 2'b00), 1'b0);
    fw_v = 1'b1; fw_d = 8'h33;
    do_frame(32'h0, 1'b0);
    chk("fw_frame_rdy", 32'(fw_rdy), 32'd0);
    do_frame(mk_word(1, 8'h33, 2'b00, 0, 15'h0, 2'b00), 1'b0);
    do_frame(mk_word(0, 8'h0, 2'b01, 0, 15'h0, 2'b00), 1'b1);
    do_frame(32'h0, 1'b0);
    mark = 2'b00;
    repeat (2) @(negedge clk);
    mark = 2'b10;
    repeat (2) @(negedge clk);
    mark = 2'b00;
    repeat (2) @(negedge clk);
    do_frame(32'h0, 1'b0);
    mark = 2'b10;
    repeat (2) @(negedge clk);
    do_frame(mk_word(0, 8'h0, 2'b10, 0, 15'h0, 2'b00), 1'b1);
    mark = 2'b00;
    repeat (2) @(negedge clk);

    // FW_DIV=3: bytes only leave on every third frame
    fw3_v = 1'b1; fw3_d = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    fw3_v = 1'b0;
    do_frame3(mk_word(1, 8'h5A, 2'b00, 0, 15'h0, 2'b00));
    fw3_v = 1'b1; fw3_d = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    fw3_v = 1'b0;
    chk("div3_rdy_a", 32'(fw3_rdy), 32'd0);
    do_frame3(32'h0);
    chk("div3_rdy_b", 32'(fw3_rdy), 32'd0);
    do_frame3(32'h0);
    chk("div3_rdy_c", 32'(fw3_rdy), 32'd0);
    do_frame3(mk_word(1, 8'hC3, 2'b00, 0, 15'h0, 2'b00));
    chk("div3_rdy_d", 32'(fw3_rdy), 32'd1);
    do_frame3(32'h0);

    // reset with every hold full
    drive(1, 2'b01, 1, 15'h0555, 1, 8'h77);
    chk("full_rc_rdy", 32'(rc_rdy), 32'd0);
    chk("full_fw_rdy", 32'(fw_rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_dat", dat, 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    chk("mid_rst_rc_rdy", 32'(rc_rdy), 32'd1);
    chk("mid_rst_tr_rdy", 32'(tr_rdy), 32'd1);
    chk("mid_rst_fw_rdy", 32'(fw_rdy), 32'd1);
    chk("mid_rst_cnt3", 32'(cnt3), 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    do_frame(32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
